// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: issues the two-pulse INTA handshake to the PIC,
// captures the vector on the second pulse and offers it to the host via valid/ready.
module inta_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INT,
    input  logic       if_enable,
    input  logic [7:0] data_in,
    output logic       INTA,
    output logic [7:0] vec_data,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic       busy,
    output logic [7:0] ack_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PULSE1   = 3'd1,
        S_GAP      = 3'd2,
        S_PULSE2   = 3'd3,
        S_HOLD     = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       int_meta_q, int_sync_q;
    logic       inta_q, inta_d;
    logic [7:0] vec_data_q, vec_data_d;
    logic       vec_valid_q, vec_valid_d;
    logic       busy_q, busy_d;
    logic [7:0] ack_q, ack_d;
    logic       cnt_zero_s;

    // Two-flop synchronizer for the asynchronous PIC request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
        end
    end

    // State, shared timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            inta_q      <= 1'b1;
            vec_data_q  <= 8'h00;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inta_q      <= inta_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
        end
    end

    // Next-state logic; once PULSE1 is entered the sequence runs to HOLD unconditionally.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_data_d  = vec_data_q;
        vec_valid_d = vec_valid_q;
        ack_d       = ack_q;
        cnt_zero_s  = (cnt_q == 4'd0);

        case (state_q)
            S_IDLE: begin
                if (int_sync_q && if_enable) begin
                    state_d = S_PULSE1;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PULSE1: begin
                if (cnt_zero_s) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_zero_s) begin
                    state_d = S_PULSE2;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_PULSE2: begin
                if (cnt_zero_s) begin
                    state_d     = S_HOLD;
                    vec_data_d  = data_in;
                    vec_valid_d = 1'b1;
                    ack_d       = ack_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (vec_valid_q && vec_ready) begin
                    state_d     = S_COOLDOWN;
                    cnt_d       = GAP_LOAD;
                    vec_valid_d = 1'b0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_COOLDOWN: begin
                if (cnt_zero_s) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = 4'd0;
                vec_valid_d = 1'b0;
            end
        endcase

        inta_d = !((state_d == S_PULSE1) || (state_d == S_PULSE2));
        busy_d = (state_d != S_IDLE);
    end

    assign INTA      = inta_q;
    assign vec_data  = vec_data_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign ack_count = ack_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: a PIC model drives the vector in the last
// cycle of each second pulse and queues it; scenario tasks pop and compare on capture.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq = 1'b0, if_en = 1'b0, vec_ready = 1'b0;
    logic [7:0] data_in = 8'hA5;
    logic       inta, vec_valid, busy;
    logic [7:0] vec_data, ack_count;

    logic       b_irq = 1'b0, b_en = 1'b0, b_ready = 1'b0;
    logic [7:0] b_data_in = 8'hA5;
    logic       b_inta, b_valid, b_busy;
    logic [7:0] b_vec_data, b_ack;

    int checks = 0;
    int failures = 0;

    logic [7:0] cur_vec = 8'h00, b_vec = 8'h00;
    logic [7:0] exp_q[$], b_q[$];
    logic [7:0] exp_ack = 8'd0;
    int a_pulses = 0, a_run = 0, b_pulses = 0, b_run = 0;

    always #5 clk = ~clk;

    inta_sequencer u_dut (
        .clk(clk), .reset(reset), .INT(irq), .if_enable(if_en), .data_in(data_in),
        .INTA(inta), .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .busy(busy), .ack_count(ack_count)
    );

    inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) u_wrap (
        .clk(clk), .reset(reset), .INT(b_irq), .if_enable(b_en), .data_in(b_data_in),
        .INTA(b_inta), .vec_data(b_vec_data), .vec_valid(b_valid), .vec_ready(b_ready),
        .busy(b_busy), .ack_count(b_ack)
    );

    // PIC model for the default instance (2-cycle pulses): vector only in last PULSE2 cycle.
    always @(negedge clk) begin
        if (reset) begin
            a_pulses = 0; a_run = 0; exp_ack = 8'd0; data_in = 8'hA5; exp_q.delete();
        end else begin
            if (inta === 1'b0) begin
                if (a_run == 0) a_pulses++;
                a_run++;
            end else a_run = 0;
            if (inta === 1'b0 && (a_pulses % 2) == 0 && a_run == 2) begin
                data_in = cur_vec;
                exp_q.push_back(cur_vec);
                exp_ack = exp_ack + 8'd1;
            end else data_in = 8'hA5;
        end
    end

    // PIC model for the 1-cycle-pulse instance.
    always @(negedge clk) begin
        if (reset) begin
            b_pulses = 0; b_run = 0; b_data_in = 8'hA5; b_q.delete();
        end else begin
            if (b_inta === 1'b0) begin
                if (b_run == 0) b_pulses++;
                b_run++;
            end else b_run = 0;
            if (b_inta === 1'b0 && (b_pulses % 2) == 0 && b_run == 1) begin
                b_data_in = b_vec;
                b_q.push_back(b_vec);
            end else b_data_in = 8'hA5;
        end
    end

    task automatic pop_exp(output logic [7:0] ev);
        if (exp_q.size() == 0) ev = 8'hxx;
        else ev = exp_q.pop_front();
    endtask

    task automatic wait_inta(input logic lvl, output int n);
        n = 0;
        while (inta !== lvl && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (inta === lvl && n < 64) begin n++; @(negedge clk); end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (vec_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || inta !== 1'b1) begin
            failures++; $display("FAIL idle: busy=%b inta=%b required busy=0 inta=1", busy, inta);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if (inta !== 1'b1 || vec_valid !== 1'b0 || vec_data !== 8'h00 || busy !== 1'b0 || ack_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: inta=%b valid=%b data=%h busy=%b ack=%0d required 1/0/00/0/0",
                     inta, vec_valid, vec_data, busy, ack_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        logic [7:0] ev;
        cur_vec = 8'h48; irq = 1'b1; if_en = 1'b1; vec_ready = 1'b1;
        wait_inta(1'b0, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL single_latency: inta fell after %0d cycles, required 3", n); end
        irq = 1'b0;
        run_len(1'b0, n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL single_pulse1: low %0d cycles, required 2", n); end
        run_len(1'b1, n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL single_gap: high %0d cycles, required 2", n); end
        run_len(1'b0, n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL single_pulse2: low %0d cycles, required 2", n); end
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev || ev !== 8'h48) begin
            failures++; $display("FAIL single_capture: valid=%b data=%h required valid=1 data=48", vec_valid, vec_data);
        end
        checks++;
        if (ack_count !== exp_ack || ack_count !== 8'd1) begin
            failures++; $display("FAIL single_ack: ack=%0d required 1", ack_count);
        end
        @(negedge clk);
        checks++;
        if (vec_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL single_handshake: valid=%b busy=%b required valid=0 busy=1", vec_valid, busy);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] ev;
        cur_vec = 8'h5C; irq = 1'b1; if_en = 1'b1; vec_ready = 1'b0;
        wait_valid(n);
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev) begin
            failures++; $display("FAIL bp_capture: valid=%b data=%h required valid=1 data=%h", vec_valid, vec_data, ev);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (vec_valid !== 1'b1 || vec_data !== 8'h5C || inta !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%h inta=%b required valid=1 data=5c inta=1",
                         i, vec_valid, vec_data, inta);
            end
        end
        vec_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (vec_valid !== 1'b0) begin failures++; $display("FAIL bp_release: valid=%b required 0", vec_valid); end
        wait_inta(1'b0, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL bp_cooldown: next inta fell %0d cycles after handshake, required 4", n + 1); end
        irq = 1'b0; cur_vec = 8'hC3;
        wait_valid(n);
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev || ev !== 8'hC3) begin
            failures++; $display("FAIL bp_second: valid=%b data=%h required valid=1 data=c3", vec_valid, vec_data);
        end
        wait_idle();
    endtask

    task automatic test_gating();
        int n;
        int bad = 0;
        logic [7:0] ev;
        cur_vec = 8'h9E; if_en = 1'b0; irq = 1'b1; vec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inta !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL gating_hold: %0d cycles with activity, required 0", bad); end
        if_en = 1'b1;
        wait_inta(1'b0, n);
        checks++;
        if (n != 1) begin failures++; $display("FAIL gating_start: inta fell after %0d cycles, required 1", n); end
        irq = 1'b0;
        wait_valid(n);
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev || ev !== 8'h9E) begin
            failures++; $display("FAIL gating_capture: valid=%b data=%h required valid=1 data=9e", vec_valid, vec_data);
        end
        wait_idle();
    endtask

    task automatic test_mid_drop();
        int n;
        logic [7:0] ev;
        logic [7:0] ack_before;
        ack_before = exp_ack;
        cur_vec = 8'h3A; irq = 1'b1; if_en = 1'b1; vec_ready = 1'b1;
        wait_inta(1'b0, n);
        run_len(1'b0, n);
        irq = 1'b0; if_en = 1'b0;
        run_len(1'b1, n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL drop_gap: high %0d cycles, required 2", n); end
        run_len(1'b0, n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL drop_pulse2: low %0d cycles, required 2", n); end
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev || ack_count !== ack_before + 8'd1) begin
            failures++;
            $display("FAIL drop_capture: valid=%b data=%h ack=%0d required valid=1 data=%h ack=%0d",
                     vec_valid, vec_data, ack_count, ev, ack_before + 8'd1);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] ev;
        cur_vec = 8'h77; irq = 1'b1; if_en = 1'b1; vec_ready = 1'b1;
        wait_inta(1'b0, n);
        run_len(1'b0, n);
        run_len(1'b1, n);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (inta !== 1'b1 || vec_valid !== 1'b0 || busy !== 1'b0 || ack_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_async: inta=%b valid=%b busy=%b ack=%0d required 1/0/0/0", inta, vec_valid, busy, ack_count);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cur_vec = 8'h66;
        wait_inta(1'b0, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL reset_restart: inta fell after %0d cycles, required 3", n); end
        irq = 1'b0;
        wait_valid(n);
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev || ev !== 8'h66 || ack_count !== 8'd1) begin
            failures++;
            $display("FAIL reset_capture: valid=%b data=%h ack=%0d required valid=1 data=66 ack=1", vec_valid, vec_data, ack_count);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] ev;
        cur_vec = 8'h11; irq = 1'b1; if_en = 1'b1; vec_ready = 1'b1;
        wait_valid(n);
        pop_exp(ev);
        checks++;
        if (vec_data !== ev || ev !== 8'h11) begin failures++; $display("FAIL b2b_first: data=%h required 11", vec_data); end
        cur_vec = 8'h22;
        wait_inta(1'b0, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL b2b_spacing: next inta fell after %0d cycles, required 4", n); end
        irq = 1'b0;
        wait_valid(n);
        pop_exp(ev);
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== ev || ev !== 8'h22) begin
            failures++; $display("FAIL b2b_second: valid=%b data=%h required valid=1 data=22", vec_valid, vec_data);
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        int n, lo1, hi, lo2;
        int bad = 0;
        logic [7:0] ev;
        b_irq = 1'b1; b_en = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b_vec = 8'(i * 7 + 3);
            n = 0;
            while (b_inta !== 1'b0 && n < 100) begin @(negedge clk); n++; end
            lo1 = 0; while (b_inta === 1'b0 && lo1 < 20) begin lo1++; @(negedge clk); end
            hi = 0;  while (b_inta === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
            lo2 = 0; while (b_inta === 1'b0 && lo2 < 20) begin lo2++; @(negedge clk); end
            if (lo1 != 1 || hi != 3 || lo2 != 1) bad++;
            if (b_q.size() == 0) ev = 8'hxx;
            else ev = b_q.pop_front();
            checks++;
            if (b_valid !== 1'b1 || b_vec_data !== ev || b_ack !== 8'(i + 1)) begin
                failures++;
                $display("FAIL wrap_capture: ack %0d valid=%b data=%h count=%0d required valid=1 data=%h count=%0d",
                         i, b_valid, b_vec_data, b_ack, ev, (i + 1) % 256);
            end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wrap_waveform: %0d sequences off-pattern, required 0", bad); end
        checks++;
        if (b_ack !== 8'd0) begin failures++; $display("FAIL wrap_count: ack=%0d required 0", b_ack); end
        b_irq = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (b_busy !== 1'b0) begin failures++; $display("FAIL wrap_idle: busy=%b required 0", b_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_gating();
        test_mid_drop();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
